// File: rtl/hand_bank.sv
// Per-hand card store with running Baccarat score, count, full and natural flags.
// Cards enter through a valid/ready deal port; a combinational read port serves the display.
module hand_bank #(
    parameter int NUM_HANDS = 2,
    parameter int MAX_CARDS = 3,
    parameter int HW        = ($clog2(NUM_HANDS) > 0) ? $clog2(NUM_HANDS) : 1,
    parameter int SW        = $clog2(MAX_CARDS),
    parameter int CW        = $clog2(MAX_CARDS + 1)
) (
    input  logic                    clk,
    input  logic                    resetb,
    input  logic                    new_round,
    input  logic                    deal_valid,
    output logic                    deal_ready,
    input  logic [HW-1:0]           deal_hand,
    input  logic [3:0]              card_in,
    output logic                    deal_err,
    input  logic [HW-1:0]           rd_hand,
    input  logic [SW-1:0]           rd_slot,
    output logic [3:0]              rd_card,
    output logic [4*NUM_HANDS-1:0]  score_out,
    output logic [CW*NUM_HANDS-1:0] count_out,
    output logic [NUM_HANDS-1:0]    full_out,
    output logic [NUM_HANDS-1:0]    natural_out
);

    logic [3:0]    slot_q  [NUM_HANDS][MAX_CARDS];
    logic [3:0]    slot_d  [NUM_HANDS][MAX_CARDS];
    logic [3:0]    score_q [NUM_HANDS];
    logic [3:0]    score_d [NUM_HANDS];
    logic [CW-1:0] count_q [NUM_HANDS];
    logic [CW-1:0] count_d [NUM_HANDS];
    logic          deal_err_q;
    logic          deal_err_d;

    logic          hand_ok;
    logic          sel_full;
    logic          xfer;
    logic          card_ok;
    logic [3:0]    card_val;
    logic [4:0]    sum;

    // Ready never looks at deal_valid or card_in, so the dealer may wait on it freely.
    always_comb begin
        hand_ok  = 1'b0;
        sel_full = 1'b0;
        for (int h = 0; h < NUM_HANDS; h++) begin
            if (deal_hand == HW'(h)) begin
                hand_ok  = 1'b1;
                sel_full = (count_q[h] == CW'(MAX_CARDS));
            end
        end
        deal_ready = resetb & ~new_round & hand_ok & ~sel_full;
    end

    assign xfer     = deal_valid & deal_ready;
    assign card_ok  = (card_in >= 4'd1) && (card_in <= 4'd13);
    assign card_val = (card_in <= 4'd9) ? card_in : 4'd0;

    always_comb begin
        slot_d     = slot_q;
        score_d    = score_q;
        count_d    = count_q;
        deal_err_d = 1'b0;
        sum        = 5'd0;
        if (new_round) begin
            for (int h = 0; h < NUM_HANDS; h++) begin
                score_d[h] = 4'd0;
                count_d[h] = '0;
                for (int s = 0; s < MAX_CARDS; s++) begin
                    slot_d[h][s] = 4'd0;
                end
            end
        end else if (xfer) begin
            if (!card_ok) begin
                deal_err_d = 1'b1;
            end else begin
                for (int h = 0; h < NUM_HANDS; h++) begin
                    if (deal_hand == HW'(h)) begin
                        // Sum of two 0..9 digits peaks at 18, so one conditional subtract suffices.
                        sum        = {1'b0, score_q[h]} + {1'b0, card_val};
                        score_d[h] = (sum >= 5'd10) ? 4'(sum - 5'd10) : sum[3:0];
                        count_d[h] = count_q[h] + CW'(1);
                        for (int s = 0; s < MAX_CARDS; s++) begin
                            if (count_q[h] == CW'(s)) begin
                                slot_d[h][s] = card_in;
                            end
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            slot_q     <= '{default: '{default: 4'd0}};
            score_q    <= '{default: 4'd0};
            count_q    <= '{default: '0};
            deal_err_q <= 1'b0;
        end else begin
            slot_q     <= slot_d;
            score_q    <= score_d;
            count_q    <= count_d;
            deal_err_q <= deal_err_d;
        end
    end

    assign deal_err = deal_err_q;

    always_comb begin
        score_out   = '0;
        count_out   = '0;
        full_out    = '0;
        natural_out = '0;
        rd_card     = 4'd0;
        for (int h = 0; h < NUM_HANDS; h++) begin
            score_out[4*h +: 4]  = score_q[h];
            count_out[CW*h +: CW] = count_q[h];
            full_out[h]          = (count_q[h] == CW'(MAX_CARDS));
            natural_out[h]       = (count_q[h] == CW'(2)) && (score_q[h] >= 4'd8);
            for (int s = 0; s < MAX_CARDS; s++) begin
                if ((rd_hand == HW'(h)) && (rd_slot == SW'(s))) begin
                    rd_card = slot_q[h][s];
                end
            end
        end
    end

endmodule

// File: tb/tb_hand_bank.sv
// Directed bench for hand_bank, built with three hands so hand index 3 is out of range.
module tb_hand_bank;

    localparam int NH = 3;
    localparam int MC = 3;
    localparam int HW = 2;
    localparam int SW = 2;
    localparam int CW = 2;

    logic            clk = 1'b0;
    logic            resetb;
    logic            new_round;
    logic            deal_valid;
    logic            deal_ready;
    logic [HW-1:0]   deal_hand;
    logic [3:0]      card_in;
    logic            deal_err;
    logic [HW-1:0]   rd_hand;
    logic [SW-1:0]   rd_slot;
    logic [3:0]      rd_card;
    logic [4*NH-1:0] score_out;
    logic [CW*NH-1:0] count_out;
    logic [NH-1:0]   full_out;
    logic [NH-1:0]   natural_out;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hand_bank #(.NUM_HANDS(NH), .MAX_CARDS(MC)) dut (
        .clk         (clk),
        .resetb      (resetb),
        .new_round   (new_round),
        .deal_valid  (deal_valid),
        .deal_ready  (deal_ready),
        .deal_hand   (deal_hand),
        .card_in     (card_in),
        .deal_err    (deal_err),
        .rd_hand     (rd_hand),
        .rd_slot     (rd_slot),
        .rd_card     (rd_card),
        .score_out   (score_out),
        .count_out   (count_out),
        .full_out    (full_out),
        .natural_out (natural_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic deal(input logic [HW-1:0] h, input logic [3:0] c);
        deal_hand  = h;
        card_in    = c;
        deal_valid = 1'b1;
        @(posedge clk);
        #1;
        deal_valid = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_chk(input string tag, input logic [HW-1:0] h, input logic [SW-1:0] s,
                          input logic [3:0] exp);
        rd_hand = h;
        rd_slot = s;
        #1;
        chk(tag, rd_card, exp);
    endtask

    initial begin
        resetb     = 1'b0;
        new_round  = 1'b0;
        deal_valid = 1'b0;
        deal_hand  = '0;
        card_in    = 4'd0;
        rd_hand    = '0;
        rd_slot    = '0;

        // reset state
        @(posedge clk);
        #1;
        chk("rst_ready", deal_ready, 1'b0);
        chk("rst_score", score_out, 12'h000);
        chk("rst_count", count_out, 6'h00);
        chk("rst_full", full_out, 3'b000);
        chk("rst_natural", natural_out, 3'b000);
        chk("rst_err", deal_err, 1'b0);
        resetb = 1'b1;
        #1;
        chk("ready_h0_empty", deal_ready, 1'b1);
        deal_hand = 2'd3;
        #1;
        chk("ready_hand_oor", deal_ready, 1'b0);

        // hand 0: 7 then 5
        deal(2'd0, 4'd7);
        chk("h0_score_c1", score_out[3:0], 4'd7);
        chk("h0_count_c1", count_out[1:0], 2'd1);
        deal(2'd0, 4'd5);
        chk("h0_score_c2", score_out[3:0], 4'd2);
        chk("h0_count_c2", count_out[1:0], 2'd2);
        chk("h0_natural_c2", natural_out[0], 1'b0);

        // hand 1: K, 9 natural, then 4 fills it
        deal(2'd1, 4'd13);
        chk("h1_score_k", score_out[7:4], 4'd0);
        deal(2'd1, 4'd9);
        chk("h1_score_9", score_out[7:4], 4'd9);
        chk("h1_natural", natural_out, 3'b010);
        deal(2'd1, 4'd4);
        chk("h1_score_4", score_out[7:4], 4'd3);
        chk("h1_natural_off", natural_out, 3'b000);
        chk("h1_full", full_out, 3'b010);
        chk("h1_ready_full", deal_ready, 1'b0);
        chk("all_score", score_out, 12'h032);
        chk("all_count", count_out, 6'h0E);

        // fill hand 0 (2+8 wraps to 0), then hold a card against it
        deal(2'd0, 4'd8);
        chk("h0_score_wrap", score_out[3:0], 4'd0);
        chk("full_both", full_out, 3'b011);
        deal_hand  = 2'd0;
        card_in    = 4'd1;
        deal_valid = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("hold_ready", deal_ready, 1'b0);
        end
        deal_valid = 1'b0;
        chk("hold_score", score_out, 12'h030);
        chk("hold_count", count_out, 6'h0F);
        rd_chk("rd_h0s0", 2'd0, 2'd0, 4'd7);
        rd_chk("rd_h0s1", 2'd0, 2'd1, 4'd5);
        rd_chk("rd_h0s2", 2'd0, 2'd2, 4'd8);
        rd_chk("rd_h1s0", 2'd1, 2'd0, 4'd13);
        rd_chk("rd_h1s1", 2'd1, 2'd1, 4'd9);
        rd_chk("rd_h1s2", 2'd1, 2'd2, 4'd4);
        rd_chk("rd_slot_oor", 2'd0, 2'd3, 4'd0);
        rd_chk("rd_hand_oor", 2'd3, 2'd0, 4'd0);
        rd_chk("rd_h2_empty", 2'd2, 2'd0, 4'd0);

        // new round clears everything
        new_round = 1'b1;
        idle();
        new_round = 1'b0;
        chk("nr_score", score_out, 12'h000);
        chk("nr_count", count_out, 6'h00);
        chk("nr_full", full_out, 3'b000);
        rd_chk("nr_rd_h0s0", 2'd0, 2'd0, 4'd0);

        // invalid codes
        deal(2'd0, 4'd0);
        chk("err_code0", deal_err, 1'b1);
        chk("err_code0_count", count_out, 6'h00);
        idle();
        chk("err_clear", deal_err, 1'b0);
        deal(2'd0, 4'd14);
        chk("err_code14", deal_err, 1'b1);
        chk("err_code14_count", count_out, 6'h00);
        deal(2'd0, 4'd6);
        chk("after_err_pulse", deal_err, 1'b0);
        chk("after_err_count", count_out[1:0], 2'd1);
        chk("after_err_score", score_out[3:0], 4'd6);
        rd_chk("after_err_slot0", 2'd0, 2'd0, 4'd6);

        // new_round beats a simultaneous deal
        deal(2'd0, 4'd3);
        chk("h0_natural9", natural_out, 3'b001);
        chk("h0_score9", score_out[3:0], 4'd9);
        new_round  = 1'b1;
        deal_hand  = 2'd0;
        card_in    = 4'd5;
        deal_valid = 1'b1;
        #1;
        chk("nr_ready", deal_ready, 1'b0);
        idle();
        new_round  = 1'b0;
        deal_valid = 1'b0;
        chk("nr_deal_score", score_out, 12'h000);
        chk("nr_deal_count", count_out, 6'h00);
        chk("nr_deal_natural", natural_out, 3'b000);
        rd_chk("nr_deal_slot2", 2'd0, 2'd2, 4'd0);

        // async reset mid-round
        deal(2'd1, 4'd2);
        deal(2'd1, 4'd3);
        deal(2'd1, 4'd4);
        chk("pre_rst_score", score_out, 12'h090);
        chk("pre_rst_full", full_out, 3'b010);
        resetb = 1'b0;
        #2;
        chk("async_score", score_out, 12'h000);
        chk("async_count", count_out, 6'h00);
        chk("async_full", full_out, 3'b000);
        chk("async_ready", deal_ready, 1'b0);
        rd_chk("async_rd_h1s0", 2'd1, 2'd0, 4'd0);
        #1;
        resetb = 1'b1;
        idle();
        rd_chk("post_rst_slot2", 2'd1, 2'd2, 4'd0);
        rd_chk("post_rst_hand_oor", 2'd3, 2'd1, 4'd0);
        chk("post_rst_count", count_out, 6'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
